sd_cmd_issue_seq: RTL and testbench
===================================

// Module: sd_cmd_issue_seq
// PURPOSE
//  Parametrised successor of the SD command-issue sequencer (host-controller spec 3.7.1.1).
//  Takes a strobed command request and polls Present State (024h) for CMD/DAT inhibit, with bounded retries.
//  Then writes Argument (008h) and Command (00Eh) over the host-controller register port.
//  Ends with a done strobe plus status code; the done strobe triggers the finalize-command block.
// PARAMETERS
//  IDX_W      12      register index width
//  DW         32      register write-data width (>=32); rd_reg_input width is 128, fixed
//  WAIT_CLKS  5       cycles waited after every rd/wr strobe before sampling / next access (1..2**CNT_W-1)
//  MAX_POLLS  8       inhibit polls per line before timeout (1..255)
//  PSTATE_OFS 12'h024 Present State register index
//  ARG_OFS    12'h008 Argument register index
//  CMD_OFS    12'h00E Command register index
// PORTS
//  clk                in   1     system clock
//  reset              in   1     asynchronous, active-low reset
//  issue_sd_cmd_strb  in   1     1-cycle request; accepted only when busy=0
//  cmd_index          in   6     command index
//  argument           in   32    command argument
//  command_type       in   2     2'b11 = abort command
//  data_pres_select   in   1     data present
//  cmd_indx_chk_enb   in   1     index check enable
//  cmd_crc_chk_enb    in   1     CRC check enable
//  resp_type_select   in   2     response type; 2'b11 = R1b (busy)
//  rd_reg_strb        out  1     1-cycle read request
//  rd_reg_index       out  IDX_W read index
//  rd_reg_input       in   128   read data; bit0 CMD inhibit, bit1 DAT inhibit
//  wr_reg_strb        out  1     1-cycle write request
//  wr_reg_index       out  IDX_W write index
//  wr_reg_output      out  DW    write data
//  reg_attr           out  3     write attribute; always 3'h0
//  busy               out  1     sequence in progress
//  fin_a_cmd_strb     out  1     1-cycle done pulse
//  status             out  2     00 ok, 01 CMD-inhibit timeout, 10 DAT-inhibit timeout; valid with fin strobe, held until next start
// BEHAVIOUR
//  Reset state
//   - All outputs 0; state IDLE; latched request 0.
//   - Reset mid-sequence aborts immediately; no further strobes are issued.
//  Request handling
//   - Accept: IDLE & issue_sd_cmd_strb. All request fields latched that cycle; later input changes are ignored.
//   - Strobes while busy are dropped silently.
//  States: IDLE, RD_CMD, WT_CMD, RD_DAT, WT_DAT, WR_ARG, WT_ARG, WR_CMD, WT_WRC, DONE.
//   - IDLE -> RD_CMD on accept; busy=1 from the next cycle.
//   - RD_CMD: rd_reg_strb=1, index PSTATE_OFS; poll_cnt++ -> WT_CMD.
//   - WT_CMD: rd_reg_index is held. After WAIT_CLKS cycles, sample bit0:
//       0 -> go to RD_DAT if need_dat, else WR_ARG;
//       1 and poll_cnt<MAX_POLLS -> RD_CMD;
//       1 otherwise -> status=01, DONE.
//   - need_dat = (data_pres_select | resp_type_select==2'b11) & command_type!=2'b11.
//   - poll_cnt clears on entry to RD_DAT.
//   - RD_DAT / WT_DAT: same as RD_CMD / WT_CMD, using bit1; timeout gives status=10.
//   - WR_ARG: wr_reg_strb=1, index ARG_OFS, data = zero-extended argument -> WT_ARG.
//   - WT_ARG: index/data held for WAIT_CLKS cycles -> WR_CMD.
//   - WR_CMD: wr_reg_strb=1, index CMD_OFS, data = zero-extended
//       {2'b0, cmd_index, command_type, data_pres, idx_chk, crc_chk, 1'b0, resp_type}.
//   - WT_WRC: hold for WAIT_CLKS cycles, then status=00 -> DONE.
//   - DONE: fin_a_cmd_strb=1 for one cycle; busy=0 on the next cycle -> IDLE.
//  Timing and boundary rules
//   - A new request is accepted in the same cycle busy falls.
//   - Happy-path latency, strobe to fin (no DAT check): 4 + 3*(WAIT_CLKS+1) cycles.
//   - MAX_POLLS=1: a single poll, with no retry.
//   - Any timeout: no write strobes are issued.
//   - Wait counter: restarts on every rd/wr strobe; terminal count WAIT_CLKS; no wrap beyond terminal.
//   - Outside read/write states, rd/wr index and data return to 0.
// STRUCTURE
//  Package sd_hc_pkg:
//   - register offsets 024h/008h/00Eh
//   - status codes
//   - state encoding (one-hot, safe recovery to IDLE)
//   - command-word pack function
//  Sub-module sd_wait_cntr:
//   - async active-low reset; start strobe; parameter MAX; 1-cycle tout pulse.
//   - Shared with the finalize-command block.
// TESTING
//  1. CMD0: arg 0, resp 00, inhibits 0. Expect:
//     - one read of 024h;
//     - write 008h = 0;
//     - write 00Eh = 32'h0000_0000;
//     - fin with status 00 at cycle 4+3*6 = 22.
//  2. CMD17: arg 32'h0000_0200, data_pres 1, resp 2'b10, CRC and index check on. Expect:
//     - two reads of 024h;
//     - 008h = 32'h200;
//     - 00Eh = 32'h113A.
//  3. CMD inhibit held 1 with MAX_POLLS=3 -> exactly 3 reads, zero writes, status 01.
//  4. DAT inhibit 1 for the first 2 polls, then 0, with CMD7 resp 2'b11 ->
//     - 1 CMD poll + 3 DAT polls;
//     - writes complete, status 00.
//  5. CMD12 abort: type 11, resp 11, DAT inhibit 1 -> no DAT poll; writes issued; 00Eh = 32'h0CDB.
//  6. Mid-sequence cases:
//     - reset asserted in WT_ARG -> outputs 0 immediately; no further strobes.
//     - second issue_sd_cmd_strb while busy -> ignored; exactly one fin pulse.

Source files
------------

// File: rtl/sd_cmd_issue_seq_pkg.sv
// Shared definitions for the SD command-issue path: register offsets, status codes,
// sequencer state encoding and the Command register word packing.
package sd_hc_pkg;

  localparam logic [11:0] HC_PSTATE_OFS = 12'h024;
  localparam logic [11:0] HC_ARG_OFS    = 12'h008;
  localparam logic [11:0] HC_CMD_OFS    = 12'h00E;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_CMD_TOUT = 2'b01,
    ST_DAT_TOUT = 2'b10
  } status_e;

  // One-hot; any other pattern is recovered to IDLE by the sequencer.
  typedef enum logic [9:0] {
    IDLE   = 10'b00_0000_0001,
    RD_CMD = 10'b00_0000_0010,
    WT_CMD = 10'b00_0000_0100,
    RD_DAT = 10'b00_0000_1000,
    WT_DAT = 10'b00_0001_0000,
    WR_ARG = 10'b00_0010_0000,
    WT_ARG = 10'b00_0100_0000,
    WR_CMD = 10'b00_1000_0000,
    WT_WRC = 10'b01_0000_0000,
    DONE   = 10'b10_0000_0000
  } seq_state_e;

  typedef struct packed {
    logic [5:0]  cmd_index;
    logic [31:0] argument;
    logic [1:0]  command_type;
    logic        data_pres;
    logic        idx_chk;
    logic        crc_chk;
    logic [1:0]  resp_type;
  } cmd_req_t;

  function automatic logic [15:0] pack_cmd_word(input cmd_req_t r);
    return {2'b00, r.cmd_index, r.command_type, r.data_pres,
            r.idx_chk, r.crc_chk, 1'b0, r.resp_type};
  endfunction

  // Data lines matter for data transfers and R1b busy, but never for an abort.
  function automatic logic need_dat_check(input cmd_req_t r);
    return (r.data_pres | (r.resp_type == 2'b11)) & (r.command_type != 2'b11);
  endfunction

endpackage

// File: rtl/sd_cmd_issue_seq_if.sv
// Host-controller register port between the command sequencer (master) and the
// register block (slave).
interface sd_cmd_issue_seq_if #(
  parameter int unsigned IDX_W = 12,
  parameter int unsigned DW    = 32
) ();

  logic             rd_reg_strb;
  logic [IDX_W-1:0] rd_reg_index;
  logic [127:0]     rd_reg_input;
  logic             wr_reg_strb;
  logic [IDX_W-1:0] wr_reg_index;
  logic [DW-1:0]    wr_reg_output;
  logic [2:0]       reg_attr;

  modport master (
    output rd_reg_strb, rd_reg_index, wr_reg_strb, wr_reg_index, wr_reg_output, reg_attr,
    input  rd_reg_input
  );

  modport slave (
    input  rd_reg_strb, rd_reg_index, wr_reg_strb, wr_reg_index, wr_reg_output, reg_attr,
    output rd_reg_input
  );

endinterface

// File: rtl/sd_cmd_issue_seq_wait_cntr.sv
// Register-access wait timer: a down-counter reloaded by every start strobe that
// emits a one-cycle tout when it reaches terminal count; it never wraps.
module sd_wait_cntr #(
  parameter int unsigned MAX   = 5,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic tout
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tout <= 1'b0;
    end else begin
      tout <= 1'b0;
      if (start) begin
        cnt <= CNT_W'(MAX);
      end else if (cnt != '0) begin
        cnt  <= cnt - 1'b1;
        tout <= (cnt == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/sd_cmd_issue_seq.sv
// SD command-issue sequencer: polls CMD/DAT inhibit with bounded retries, then writes
// the Argument and Command registers and reports completion with a status code.
//
// state  | meaning
// IDLE   | waiting for issue_sd_cmd_strb
// RD_CMD | Present State read strobe, CMD-inhibit poll
// WT_CMD | read settle; sample CMD inhibit on timer expiry
// RD_DAT | Present State read strobe, DAT-inhibit poll
// WT_DAT | read settle; sample DAT inhibit on timer expiry
// WR_ARG | Argument register write strobe
// WT_ARG | hold Argument write for the wait time
// WR_CMD | Command register write strobe
// WT_WRC | hold Command write for the wait time
// DONE   | fin_a_cmd_strb pulse, status valid
module sd_cmd_issue_seq
  import sd_hc_pkg::*;
#(
  parameter int unsigned      IDX_W      = 12,
  parameter int unsigned      DW         = 32,
  parameter int unsigned      WAIT_CLKS  = 5,
  parameter int unsigned      MAX_POLLS  = 8,
  parameter logic [IDX_W-1:0] PSTATE_OFS = IDX_W'(HC_PSTATE_OFS),
  parameter logic [IDX_W-1:0] ARG_OFS    = IDX_W'(HC_ARG_OFS),
  parameter logic [IDX_W-1:0] CMD_OFS    = IDX_W'(HC_CMD_OFS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_sd_cmd_strb,
  input  logic [5:0]                cmd_index,
  input  logic [31:0]               argument,
  input  logic [1:0]                command_type,
  input  logic                      data_pres_select,
  input  logic                      cmd_indx_chk_enb,
  input  logic                      cmd_crc_chk_enb,
  input  logic [1:0]                resp_type_select,
  sd_cmd_issue_seq_if.master        reg_bus,
  output logic                      busy,
  output logic                      fin_a_cmd_strb,
  output logic [1:0]                status
);

  seq_state_e       state;
  cmd_req_t         req;
  cmd_req_t         req_in;
  status_e          status_q;
  logic [7:0]       poll_cnt;
  logic             rd_strb_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic             wr_strb_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [DW-1:0]    wr_data_q;
  logic             tout;
  logic             cmd_inhibit;
  logic             dat_inhibit;
  logic             polls_left;
  logic             unused_rd_bits;

  assign req_in.cmd_index    = cmd_index;
  assign req_in.argument     = argument;
  assign req_in.command_type = command_type;
  assign req_in.data_pres    = data_pres_select;
  assign req_in.idx_chk      = cmd_indx_chk_enb;
  assign req_in.crc_chk      = cmd_crc_chk_enb;
  assign req_in.resp_type    = resp_type_select;

  assign cmd_inhibit    = reg_bus.rd_reg_input[0];
  assign dat_inhibit    = reg_bus.rd_reg_input[1];
  assign unused_rd_bits = ^reg_bus.rd_reg_input[127:2];
  assign polls_left     = (poll_cnt < 8'(MAX_POLLS));

  sd_wait_cntr #(.MAX(WAIT_CLKS)) u_wait (
    .clk   (clk),
    .reset (reset),
    .start (rd_strb_q | wr_strb_q),
    .tout  (tout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      req            <= '0;
      poll_cnt       <= '0;
      rd_strb_q      <= 1'b0;
      rd_idx_q       <= '0;
      wr_strb_q      <= 1'b0;
      wr_idx_q       <= '0;
      wr_data_q      <= '0;
      busy           <= 1'b0;
      fin_a_cmd_strb <= 1'b0;
      status_q       <= ST_OK;
    end else begin
      rd_strb_q      <= 1'b0;
      wr_strb_q      <= 1'b0;
      fin_a_cmd_strb <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_sd_cmd_strb) begin
            req       <= req_in;
            poll_cnt  <= '0;
            busy      <= 1'b1;
            status_q  <= ST_OK;
            rd_strb_q <= 1'b1;
            rd_idx_q  <= PSTATE_OFS;
            state     <= RD_CMD;
          end
        end
        RD_CMD: begin
          poll_cnt <= poll_cnt + 8'd1;
          state    <= WT_CMD;
        end
        WT_CMD: begin
          if (tout) begin
            if (!cmd_inhibit) begin
              if (need_dat_check(req)) begin
                poll_cnt  <= '0;
                rd_strb_q <= 1'b1;
                state     <= RD_DAT;
              end else begin
                rd_idx_q  <= '0;
                wr_strb_q <= 1'b1;
                wr_idx_q  <= ARG_OFS;
                wr_data_q <= DW'(req.argument);
                state     <= WR_ARG;
              end
            end else if (polls_left) begin
              rd_strb_q <= 1'b1;
              state     <= RD_CMD;
            end else begin
              rd_idx_q       <= '0;
              status_q       <= ST_CMD_TOUT;
              fin_a_cmd_strb <= 1'b1;
              state          <= DONE;
            end
          end
        end
        RD_DAT: begin
          poll_cnt <= poll_cnt + 8'd1;
          state    <= WT_DAT;
        end
        WT_DAT: begin
          if (tout) begin
            if (!dat_inhibit) begin
              rd_idx_q  <= '0;
              wr_strb_q <= 1'b1;
              wr_idx_q  <= ARG_OFS;
              wr_data_q <= DW'(req.argument);
              state     <= WR_ARG;
            end else if (polls_left) begin
              rd_strb_q <= 1'b1;
              state     <= RD_DAT;
            end else begin
              rd_idx_q       <= '0;
              status_q       <= ST_DAT_TOUT;
              fin_a_cmd_strb <= 1'b1;
              state          <= DONE;
            end
          end
        end
        WR_ARG: state <= WT_ARG;
        WT_ARG: begin
          if (tout) begin
            wr_strb_q <= 1'b1;
            wr_idx_q  <= CMD_OFS;
            wr_data_q <= DW'(pack_cmd_word(req));
            state     <= WR_CMD;
          end
        end
        WR_CMD: state <= WT_WRC;
        WT_WRC: begin
          if (tout) begin
            wr_idx_q       <= '0;
            wr_data_q      <= '0;
            status_q       <= ST_OK;
            fin_a_cmd_strb <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rd_idx_q  <= '0;
          wr_idx_q  <= '0;
          wr_data_q <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign reg_bus.rd_reg_strb   = rd_strb_q;
  assign reg_bus.rd_reg_index  = rd_idx_q;
  assign reg_bus.wr_reg_strb   = wr_strb_q;
  assign reg_bus.wr_reg_index  = wr_idx_q;
  assign reg_bus.wr_reg_output = wr_data_q;
  assign reg_bus.reg_attr      = 3'h0;
  assign status                = status_q;

endmodule

// File: tb/tb_sd_cmd_issue_seq.sv
// Directed bench for sd_cmd_issue_seq: command flows, inhibit retries/timeouts,
// abort handling, back-to-back issue, busy drop and mid-sequence reset.
module tb_sd_cmd_issue_seq;

  localparam int W = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        strb = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] argument = '0;
  logic [1:0]  command_type = '0;
  logic        data_pres_select = 1'b0;
  logic        cmd_indx_chk_enb = 1'b0;
  logic        cmd_crc_chk_enb = 1'b0;
  logic [1:0]  resp_type_select = '0;
  logic [127:0] rd_in = '0;
  logic        busy, fin, busy1, fin1;
  logic [1:0]  status, status1;

  int checks = 0;
  int failures = 0;
  int rd_cnt, wr_cnt, rd1_cnt, wr1_cnt, fin_cnt, bad_rd_idx;
  logic [11:0] wr_idx_q [4];
  logic [31:0] wr_dat_q [4];

  always #5 clk = ~clk;

  sd_cmd_issue_seq_if #(.IDX_W(12), .DW(32)) bus0 ();
  sd_cmd_issue_seq_if #(.IDX_W(12), .DW(32)) bus1 ();
  assign bus0.rd_reg_input = rd_in;
  assign bus1.rd_reg_input = rd_in;

  sd_cmd_issue_seq #(.WAIT_CLKS(W), .MAX_POLLS(3)) dut (
    .clk(clk), .reset(reset), .issue_sd_cmd_strb(strb), .cmd_index(cmd_index),
    .argument(argument), .command_type(command_type), .data_pres_select(data_pres_select),
    .cmd_indx_chk_enb(cmd_indx_chk_enb), .cmd_crc_chk_enb(cmd_crc_chk_enb),
    .resp_type_select(resp_type_select), .reg_bus(bus0), .busy(busy),
    .fin_a_cmd_strb(fin), .status(status)
  );

  sd_cmd_issue_seq #(.WAIT_CLKS(W), .MAX_POLLS(1)) dut1 (
    .clk(clk), .reset(reset), .issue_sd_cmd_strb(strb), .cmd_index(cmd_index),
    .argument(argument), .command_type(command_type), .data_pres_select(data_pres_select),
    .cmd_indx_chk_enb(cmd_indx_chk_enb), .cmd_crc_chk_enb(cmd_crc_chk_enb),
    .resp_type_select(resp_type_select), .reg_bus(bus1), .busy(busy1),
    .fin_a_cmd_strb(fin1), .status(status1)
  );

  always @(posedge clk) begin
    #1;
    if (bus0.rd_reg_strb) begin
      rd_cnt++;
      if (bus0.rd_reg_index != 12'h024) bad_rd_idx++;
    end
    if (bus0.wr_reg_strb) begin
      if (wr_cnt < 4) begin
        wr_idx_q[wr_cnt] = bus0.wr_reg_index;
        wr_dat_q[wr_cnt] = bus0.wr_reg_output;
      end
      wr_cnt++;
    end
    if (fin) fin_cnt++;
    if (bus1.rd_reg_strb) rd1_cnt++;
    if (bus1.wr_reg_strb) wr1_cnt++;
  end

  task automatic clr_mon();
    rd_cnt = 0; wr_cnt = 0; rd1_cnt = 0; wr1_cnt = 0; fin_cnt = 0; bad_rd_idx = 0;
    for (int i = 0; i < 4; i++) begin wr_idx_q[i] = '0; wr_dat_q[i] = '0; end
  endtask

  task automatic set_req(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                         input logic dp, input logic ic, input logic cc, input logic [1:0] rt);
    cmd_index = idx; argument = arg; command_type = typ; data_pres_select = dp;
    cmd_indx_chk_enb = ic; cmd_crc_chk_enb = cc; resp_type_select = rt;
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 (strobe was cycle 0).
  task automatic pulse_strb();
    strb = 1'b1;
    @(negedge clk);
    strb = 1'b0;
  endtask

  // Returns the cycle index (strobe = 0) at which fin is seen, bounded.
  task automatic wait_fin(output int lat);
    lat = 1;
    while (!fin && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, fin, status, bus0.rd_reg_strb, bus0.wr_reg_strb, bus0.rd_reg_index,
         bus0.wr_reg_index, bus0.wr_reg_output, bus0.reg_attr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b fin=%b status=%b rd_idx=%h wr_idx=%h wr_data=%h, want all 0",
               busy, fin, status, bus0.rd_reg_index, bus0.wr_reg_index, bus0.wr_reg_output);
    end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_cmd0();
    int lat;
    clr_mon();
    set_req(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    rd_in = {126'h3ABC_DEF0_1234_5678_9ABC_DEF0_1234_5678, 2'b00};
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL cmd0_busy_pre: got %b want 0", busy); end
    pulse_strb();
    checks++;
    if ({busy, bus0.rd_reg_strb, bus0.rd_reg_index} !== {1'b1, 1'b1, 12'h024}) begin
      failures++;
      $display("FAIL cmd0_first_read: busy=%b rd_strb=%b rd_idx=%h want 1 1 024",
               busy, bus0.rd_reg_strb, bus0.rd_reg_index);
    end
    wait_fin(lat);
    checks++;
    if (lat !== 22) begin failures++; $display("FAIL cmd0_latency: got %0d want 22", lat); end
    checks++;
    if (status !== 2'b00) begin failures++; $display("FAIL cmd0_status: got %b want 00", status); end
    idle(3);
    checks++;
    if ({rd_cnt, wr_cnt} !== {32'd1, 32'd2}) begin
      failures++; $display("FAIL cmd0_counts: rd=%0d wr=%0d want 1 2", rd_cnt, wr_cnt);
    end
    checks++;
    if ({wr_idx_q[0], wr_dat_q[0], wr_idx_q[1], wr_dat_q[1]} !== {12'h008, 32'h0, 12'h00E, 32'h0}) begin
      failures++;
      $display("FAIL cmd0_writes: %h=%h %h=%h want 008=0 00E=0",
               wr_idx_q[0], wr_dat_q[0], wr_idx_q[1], wr_dat_q[1]);
    end
    checks++;
    if ({busy, bus0.rd_reg_index, bus0.wr_reg_index, bus0.wr_reg_output, status} !== '0) begin
      failures++;
      $display("FAIL cmd0_idle_outputs: busy=%b rd_idx=%h wr_idx=%h wr_data=%h status=%b want 0",
               busy, bus0.rd_reg_index, bus0.wr_reg_index, bus0.wr_reg_output, status);
    end
  endtask

  task automatic test_cmd17();
    int lat;
    clr_mon();
    set_req(6'd17, 32'h0000_0200, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10);
    rd_in = '0;
    pulse_strb();
    wait_fin(lat);
    checks++;
    if ({lat, status} !== {32'd29, 2'b00}) begin
      failures++; $display("FAIL cmd17_fin: lat=%0d status=%b want 29 00", lat, status);
    end
    idle(3);
    checks++;
    if ({rd_cnt, wr_cnt, bad_rd_idx} !== {32'd2, 32'd2, 32'd0}) begin
      failures++;
      $display("FAIL cmd17_counts: rd=%0d wr=%0d bad_idx=%0d want 2 2 0", rd_cnt, wr_cnt, bad_rd_idx);
    end
    checks++;
    if ({wr_idx_q[0], wr_dat_q[0], wr_idx_q[1], wr_dat_q[1]} !== {12'h008, 32'h200, 12'h00E, 32'h113A}) begin
      failures++;
      $display("FAIL cmd17_writes: %h=%h %h=%h want 008=200 00E=113a",
               wr_idx_q[0], wr_dat_q[0], wr_idx_q[1], wr_dat_q[1]);
    end
  endtask

  task automatic test_cmd_tout();
    int lat;
    clr_mon();
    set_req(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    rd_in = 128'h1;
    pulse_strb();
    wait_fin(lat);
    checks++;
    if ({lat, status} !== {32'd22, 2'b01}) begin
      failures++; $display("FAIL cmd_tout_fin: lat=%0d status=%b want 22 01", lat, status);
    end
    idle(3);
    checks++;
    if ({rd_cnt, wr_cnt} !== {32'd3, 32'd0}) begin
      failures++; $display("FAIL cmd_tout_counts: rd=%0d wr=%0d want 3 0", rd_cnt, wr_cnt);
    end
    checks++;
    if ({rd1_cnt, wr1_cnt, status1} !== {32'd1, 32'd0, 2'b01}) begin
      failures++;
      $display("FAIL single_poll: rd=%0d wr=%0d status=%b want 1 0 01", rd1_cnt, wr1_cnt, status1);
    end
  endtask

  task automatic test_dat_tout();
    int lat;
    clr_mon();
    set_req(6'd17, 32'h0000_0200, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10);
    rd_in = 128'h2;
    pulse_strb();
    wait_fin(lat);
    checks++;
    if ({lat, status} !== {32'd29, 2'b10}) begin
      failures++; $display("FAIL dat_tout_fin: lat=%0d status=%b want 29 10", lat, status);
    end
    idle(3);
    checks++;
    if ({rd_cnt, wr_cnt} !== {32'd4, 32'd0}) begin
      failures++; $display("FAIL dat_tout_counts: rd=%0d wr=%0d want 4 0", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_dat_retry();
    int lat;
    clr_mon();
    set_req(6'd7, 32'h0007_0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11);
    rd_in = 128'h2;
    pulse_strb();
    lat = 1;
    while (!fin && lat < 300) begin
      if (rd_cnt >= 4) rd_in = '0;
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({lat, status} !== {32'd43, 2'b00}) begin
      failures++; $display("FAIL dat_retry_fin: lat=%0d status=%b want 43 00", lat, status);
    end
    idle(3);
    checks++;
    if ({rd_cnt, wr_cnt, wr_dat_q[0], wr_dat_q[1]} !== {32'd4, 32'd2, 32'h0007_0000, 32'h0703}) begin
      failures++;
      $display("FAIL dat_retry_writes: rd=%0d wr=%0d arg=%h cmd=%h want 4 2 00070000 0703",
               rd_cnt, wr_cnt, wr_dat_q[0], wr_dat_q[1]);
    end
  endtask

  task automatic test_abort();
    int lat;
    clr_mon();
    set_req(6'd12, 32'h0, 2'b11, 1'b0, 1'b1, 1'b1, 2'b11);
    rd_in = 128'h2;
    pulse_strb();
    wait_fin(lat);
    checks++;
    if ({lat, status} !== {32'd22, 2'b00}) begin
      failures++; $display("FAIL abort_fin: lat=%0d status=%b want 22 00", lat, status);
    end
    idle(3);
    checks++;
    if ({rd_cnt, wr_cnt, wr_idx_q[1], wr_dat_q[1]} !== {32'd1, 32'd2, 12'h00E, 32'h0CDB}) begin
      failures++;
      $display("FAIL abort_writes: rd=%0d wr=%0d idx=%h cmd=%h want 1 2 00E 0cdb",
               rd_cnt, wr_cnt, wr_idx_q[1], wr_dat_q[1]);
    end
    rd_in = '0;
  endtask

  task automatic test_back_to_back();
    int lat;
    clr_mon();
    set_req(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    pulse_strb();
    wait_fin(lat);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_drop: got %b want 0", busy); end
    set_req(6'd5, 32'hCAFE_0001, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    pulse_strb();
    checks++;
    if ({busy, bus0.rd_reg_strb} !== 2'b11) begin
      failures++; $display("FAIL b2b_accept: busy=%b rd_strb=%b want 1 1", busy, bus0.rd_reg_strb);
    end
    wait_fin(lat);
    idle(3);
    checks++;
    if ({fin_cnt, wr_cnt, wr_dat_q[2], wr_dat_q[3]} !== {32'd2, 32'd4, 32'hCAFE_0001, 32'h0500}) begin
      failures++;
      $display("FAIL b2b_second: fin=%0d wr=%0d arg=%h cmd=%h want 2 4 cafe0001 0500",
               fin_cnt, wr_cnt, wr_dat_q[2], wr_dat_q[3]);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    clr_mon();
    set_req(6'd17, 32'h1234_5678, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10);
    pulse_strb();
    idle(3);
    set_req(6'd0, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    pulse_strb();
    wait_fin(lat);
    idle(40);
    checks++;
    if ({fin_cnt, rd_cnt, wr_cnt} !== {32'd1, 32'd2, 32'd2}) begin
      failures++;
      $display("FAIL busy_drop_counts: fin=%0d rd=%0d wr=%0d want 1 2 2", fin_cnt, rd_cnt, wr_cnt);
    end
    checks++;
    if ({wr_dat_q[0], wr_dat_q[1]} !== {32'h1234_5678, 32'h113A}) begin
      failures++;
      $display("FAIL latched_req: arg=%h cmd=%h want 12345678 113a", wr_dat_q[0], wr_dat_q[1]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clr_mon();
    set_req(6'd0, 32'h0000_00AA, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    pulse_strb();
    n = 0;
    while (wr_cnt < 1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (wr_cnt !== 1) begin failures++; $display("FAIL mid_reach_wt_arg: wr=%0d want 1", wr_cnt); end
    idle(2);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, fin, bus0.wr_reg_strb, bus0.wr_reg_index, bus0.wr_reg_output, bus0.rd_reg_strb} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: busy=%b wr_idx=%h wr_data=%h want 0",
               busy, bus0.wr_reg_index, bus0.wr_reg_output);
    end
    @(negedge clk);
    reset = 1'b1;
    idle(30);
    checks++;
    if ({wr_cnt, rd_cnt, fin_cnt, busy} !== {32'd1, 32'd1, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_quiet: wr=%0d rd=%0d fin=%0d busy=%b want 1 1 0 0",
               wr_cnt, rd_cnt, fin_cnt, busy);
    end
  endtask

  initial begin
    clr_mon();
    idle(3);
    test_reset();
    test_cmd0();
    test_cmd17();
    test_cmd_tout();
    test_dat_tout();
    test_dat_retry();
    test_abort();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
